// File: rtl/mvau_defn_pkg.sv
// Shared MVU/MVAU definitions: popcount accumulator FSM encoding and width helpers.
// Contents:
//   popacc_state_t          - popcount accumulator FSM states
//   pc_width(simd)          - width of one SIMD popcount beat (0..simd)
//   acc_width(simd, sf)     - width of a full-row popcount sum (0..simd*sf)
package mvau_defn;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } popacc_state_t;

    function automatic int unsigned pc_width(input int unsigned simd);
        return $clog2(simd + 1);
    endfunction

    function automatic int unsigned acc_width(input int unsigned simd, input int unsigned sf);
        return $clog2(simd * sf + 1);
    endfunction

endpackage

// File: rtl/mvu_pe_popcount_acc_obuf.sv
// Single-entry valid/ready output register for the PE popcount accumulator.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   load       - a completed row result is presented this cycle
//   load_val   - value of the completed row
//   out_rdy    - downstream accepts the held result
//   out_v      - held result valid (registered)
//   out_acc    - held result (registered, stable while out_v && !out_rdy)
//   in_rdy     - combinational: upstream may proceed unless the result is blocked
module mvu_pe_popcount_acc_obuf #(
    parameter int unsigned TO = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TO-1:0] load_val,
    input  logic          out_rdy,
    output logic          out_v,
    output logic [TO-1:0] out_acc,
    output logic          in_rdy
);

    logic          out_v_q;
    logic          out_v_d;
    logic [TO-1:0] out_acc_q;
    logic [TO-1:0] out_acc_d;

    // A load only happens when the slot is empty or being taken, so it always wins.
    always_comb begin
        out_v_d   = out_v_q;
        out_acc_d = out_acc_q;
        if (load) begin
            out_v_d   = 1'b1;
            out_acc_d = load_val;
        end else if (out_v_q && out_rdy) begin
            out_v_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_v_q   <= 1'b0;
            out_acc_q <= '0;
        end else begin
            out_v_q   <= out_v_d;
            out_acc_q <= out_acc_d;
        end
    end

    assign out_v   = out_v_q;
    assign out_acc = out_acc_q;
    assign in_rdy  = !(out_v_q && !out_rdy);

endmodule

// File: rtl/mvu_pe_popcount_acc.sv
// PE popcount accumulator: sums SF popcount beats (one per synapse fold) into a
// full-row binary dot-product count and presents it on a valid/ready output.
// Optional build macro BIPOLAR_OUT_EN: output becomes the signed bipolar dot
// product 2*count - SIMD*SF instead of the raw unsigned count.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   in_v      - popcount beat valid
//   in_rdy    - block can accept a beat (combinational)
//   in_pc     - popcount of the current SIMD beat, 0..SIMD
//   out_v     - accumulated result valid
//   out_rdy   - downstream accepts the result
//   out_acc   - accumulated result (unsigned, or signed with BIPOLAR_OUT_EN)
module mvu_pe_popcount_acc
    import mvau_defn::*;
#(
    parameter  int unsigned SIMD = 2,
    parameter  int unsigned SF   = 4,
    parameter  int unsigned TO   = 16,
    localparam int unsigned TI   = pc_width(SIMD)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_v,
    output logic          in_rdy,
    input  logic [TI-1:0] in_pc,
    output logic          out_v,
    input  logic          out_rdy,
    output logic [TO-1:0] out_acc
);

    localparam int unsigned AW = acc_width(SIMD, SF);
    localparam int unsigned CW = (SF > 1) ? $clog2(SF) : 1;
`ifdef BIPOLAR_OUT_EN
    localparam int unsigned TO_MIN = AW + 1;
`else
    localparam int unsigned TO_MIN = AW;
`endif

    // Elaboration-time parameter sanity.
    generate
        if (SF == 0) begin : g_bad_sf
            $error("mvu_pe_popcount_acc: SF must be at least 1");
        end
        if (TO < TO_MIN) begin : g_bad_to
            $error("mvu_pe_popcount_acc: TO too narrow for SIMD*SF result");
        end
    endgenerate

    popacc_state_t state_q;
    popacc_state_t state_d;
    logic [AW-1:0] acc_q;
    logic [AW-1:0] acc_d;
    logic [CW-1:0] sf_cnt_q;
    logic [CW-1:0] sf_cnt_d;
    logic          beat;
    logic          last_beat;
    logic          cmpl;
    logic [AW-1:0] sum;
    logic [TO-1:0] res;

    assign beat = in_v && in_rdy;

    // With SF==1 every beat closes a row; otherwise the final fold closes it.
    assign last_beat = (SF == 1) ? 1'b1
                                 : ((state_q == S_ACC) && (sf_cnt_q == CW'(SF - 1)));

    // Idle holds no partial sum, so the running sum starts from the beat alone.
    assign sum = ((state_q == S_ACC) ? acc_q : '0) + AW'(in_pc);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (beat && !last_beat) state_d = S_ACC;
            S_ACC:  if (beat && last_beat)  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: accumulator / fold counter updates and row completion.
    always_comb begin
        acc_d    = acc_q;
        sf_cnt_d = sf_cnt_q;
        cmpl     = 1'b0;
        if (beat) begin
            if (last_beat) begin
                cmpl     = 1'b1;
                acc_d    = '0;
                sf_cnt_d = '0;
            end else begin
                acc_d    = sum;
                sf_cnt_d = sf_cnt_q + CW'(1);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            sf_cnt_q <= '0;
        end else begin
            acc_q    <= acc_d;
            sf_cnt_q <= sf_cnt_d;
        end
    end

    // Result formatting happens in the completion cycle so latency is unchanged.
`ifdef BIPOLAR_OUT_EN
    assign res = (TO'(sum) << 1) - TO'(SIMD * SF);
`else
    assign res = TO'(sum);
`endif

    // Popcount beats larger than SIMD cannot come from a legal popcount adder.
    always_ff @(posedge clk) begin
        if (!rst && beat) begin
            assert (in_pc <= TI'(SIMD));
        end
    end

    mvu_pe_popcount_acc_obuf #(
        .TO (TO)
    ) u_obuf (
        .clk      (clk),
        .rst      (rst),
        .load     (cmpl),
        .load_val (res),
        .out_rdy  (out_rdy),
        .out_v    (out_v),
        .out_acc  (out_acc),
        .in_rdy   (in_rdy)
    );

endmodule
